// File: rtl/key_debounce_oneshot.sv
// Push-button conditioner: two-flop synchroniser, stable-time debounce FSM and
// one-cycle press pulse per key, plus aggregate pulse, multi-press flag and press counter.
module key_debounce_oneshot #(
    parameter int unsigned N_KEYS          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] btn_raw,
    output logic [N_KEYS-1:0] btn_level,
    output logic [N_KEYS-1:0] btn_pulse,
    output logic              oneshotted_or,
    output logic              multi_press,
    output logic [7:0]        press_count
);

    localparam int unsigned       CntW    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0]   CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_KEYS-1:0] RelLvl  = {N_KEYS{KEY_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        StReleased,
        StPressPending,
        StPressed,
        StReleasePending
    } key_state_e;

    key_state_e        state_q [N_KEYS];
    key_state_e        state_d [N_KEYS];
    logic [CntW-1:0]   cnt_q   [N_KEYS];
    logic [CntW-1:0]   cnt_d   [N_KEYS];

    logic [N_KEYS-1:0] s1_q, s2_q;
    logic [N_KEYS-1:0] pressed;
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] pulse_q, pulse_d;
    logic              or_q, or_d;
    logic              multi_q, multi_d;
    logic [7:0]        count_q, count_d;
    int unsigned       n_lvl;

    // Released pins read as RelLvl, so XOR yields 1 exactly when pressed.
    assign pressed = s2_q ^ RelLvl;

    always_comb begin
        level_d = '0;
        pulse_d = '0;
        count_d = count_q;
        n_lvl   = 0;
        for (int k = 0; k < int'(N_KEYS); k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                StReleased: begin
                    if (pressed[k]) begin
                        state_d[k] = StPressPending;
                        cnt_d[k]   = '0;
                    end
                end
                StPressPending: begin
                    if (!pressed[k]) begin
                        state_d[k] = StReleased;
                    end else if (cnt_q[k] == CntMax) begin
                        state_d[k] = StPressed;
                        pulse_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
                StPressed: begin
                    if (!pressed[k]) begin
                        state_d[k] = StReleasePending;
                        cnt_d[k]   = '0;
                    end
                end
                StReleasePending: begin
                    if (pressed[k]) begin
                        state_d[k] = StPressed;
                    end else if (cnt_q[k] == CntMax) begin
                        state_d[k] = StReleased;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
                default: state_d[k] = StReleased;
            endcase
            level_d[k] = (state_d[k] == StPressed) || (state_d[k] == StReleasePending);
            count_d    = count_d + 8'(pulse_d[k]);
            n_lvl      = n_lvl + 32'(level_d[k]);
        end
        or_d    = |pulse_d;
        multi_d = (n_lvl > 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= RelLvl;
            s2_q    <= RelLvl;
            for (int k = 0; k < int'(N_KEYS); k++) begin
                state_q[k] <= StReleased;
                cnt_q[k]   <= '0;
            end
            level_q <= '0;
            pulse_q <= '0;
            or_q    <= 1'b0;
            multi_q <= 1'b0;
            count_q <= '0;
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            for (int k = 0; k < int'(N_KEYS); k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            level_q <= level_d;
            pulse_q <= pulse_d;
            or_q    <= or_d;
            multi_q <= multi_d;
            count_q <= count_d;
        end
    end

    assign btn_level     = level_q;
    assign btn_pulse     = pulse_q;
    assign oneshotted_or = or_q;
    assign multi_press   = multi_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_key_debounce_oneshot.sv
// Scoreboard bench for key_debounce_oneshot: a run-length reference model predicts pulses
// into a queue; a negedge monitor pops and compares, and directed tasks probe latency/reset.
module tb_key_debounce_oneshot;

    localparam int unsigned NK = 3;
    localparam int unsigned D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NK-1:0] btn_raw = '1;
    logic [NK-1:0] btn_level, btn_pulse;
    logic          oneshotted_or, multi_press;
    logic [7:0]    press_count;

    key_debounce_oneshot #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (D),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .btn_pulse     (btn_pulse),
        .oneshotted_or (oneshotted_or),
        .multi_press   (multi_press),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a key flips its accepted level once the synchronised pressed value
    // has disagreed with it for D+1 consecutive edges; the pressed value lags the pin by 2.
    typedef struct {
        int unsigned   edge_n;
        logic [NK-1:0] mask;
    } exp_t;

    exp_t          exp_q[$];
    int unsigned   cur_edge = 0;
    logic [NK-1:0] h1 = '0, h2 = '0;
    logic [NK-1:0] m_lvl = '0;
    int            m_run [NK];
    int            m_count = 0;
    logic [NK-1:0] mask;
    logic          p;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            h1 = '0;
            h2 = '0;
            m_lvl = '0;
            for (int k = 0; k < NK; k++) m_run[k] = 0;
            m_count = 0;
            exp_q.delete();
        end else begin
            cur_edge++;
            mask = '0;
            for (int k = 0; k < NK; k++) begin
                p = h2[k];
                h2[k] = h1[k];
                h1[k] = ~btn_raw[k];
                if (p != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D + 1) begin
                        m_lvl[k] = p;
                        m_run[k] = 0;
                        if (p) mask[k] = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_count = (m_count + $countones(mask)) % 256;
            if (mask != '0) exp_q.push_back('{cur_edge, mask});
        end
    end

    logic [NK-1:0] mon_exp;

    always @(negedge clk) begin
        if (rst) begin
            mon_exp = '0;
            while (exp_q.size() > 0 && exp_q[0].edge_n < cur_edge) begin
                check("pulse_missed_edge", cur_edge, exp_q[0].edge_n);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].edge_n == cur_edge) mon_exp = exp_q.pop_front().mask;
            check("sb_pulse", btn_pulse, mon_exp);
            check("sb_or", oneshotted_or, |mon_exp);
            check("sb_level", btn_level, m_lvl);
            check("sb_multi", multi_press, $countones(m_lvl) > 1);
            check("sb_count", press_count, m_count);
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_level"}, btn_level, 0);
        check({tag, "_pulse"}, btn_pulse, 0);
        check({tag, "_or"}, oneshotted_or, 0);
        check({tag, "_multi"}, multi_press, 0);
        check({tag, "_count"}, press_count, 0);
    endtask

    // Returns the number of posedges until btn_pulse is seen, or -1 on timeout.
    task automatic wait_pulse(input int max_edges, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (btn_pulse == '0 && edges < max_edges);
        if (btn_pulse == '0) edges = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int            lat;
    int            hold [NK];

    initial begin
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        idle(5);

        // Single press on key 0
        btn_raw[0] = 1'b0;
        wait_pulse(20, lat);
        check("t1_latency", lat, D + 3);
        check("t1_pulse", btn_pulse, 3'b001);
        check("t1_or", oneshotted_or, 1);
        check("t1_count", press_count, 1);
        @(posedge clk);
        #1;
        check("t1_pulse_gone", btn_pulse, 0);
        check("t1_level_held", btn_level[0], 1);
        idle(1);
        btn_raw[0] = 1'b1;
        idle(12);

        // Bounce on key 1
        for (int i = 0; i < 10; i++) begin
            btn_raw[1] = ~btn_raw[1];
            idle(2);
        end
        idle(10);
        check("t2_level", btn_level[1], 0);
        check("t2_count", press_count, 1);

        // Hold, release glitch, genuine release, re-press on key 2
        btn_raw[2] = 1'b0;
        idle(10);
        btn_raw[2] = 1'b1;
        idle(2);
        btn_raw[2] = 1'b0;
        idle(10);
        check("t3_level_glitch", btn_level[2], 1);
        check("t3_count", press_count, 2);
        btn_raw[2] = 1'b1;
        idle(10);
        check("t3_level_release", btn_level[2], 0);
        btn_raw[2] = 1'b0;
        wait_pulse(20, lat);
        check("t3_repress_latency", lat, D + 3);
        check("t3_repress_pulse", btn_pulse, 3'b100);
        idle(1);
        btn_raw[2] = 1'b1;
        idle(12);

        // Simultaneous press
        btn_raw = 3'b000;
        wait_pulse(20, lat);
        check("t4_latency", lat, D + 3);
        check("t4_pulse", btn_pulse, 3'b111);
        check("t4_multi", multi_press, 1);
        check("t4_count", press_count, 6);
        idle(1);
        btn_raw = 3'b111;
        idle(12);
        check("t4_multi_clear", multi_press, 0);

        // Counter wrap
        rst = 1'b0;
        #1;
        check_zero("t5_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) check("t5_before_wrap", press_count, 8'hFF);
            btn_raw[0] = 1'b0;
            idle(9);
            btn_raw[0] = 1'b1;
            idle(9);
        end
        check("t5_after_wrap", press_count, 8'h00);

        // Reset during PRESS_PENDING with key held through it
        btn_raw[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_zero("t6_pending_reset");
        @(negedge clk);
        rst = 1'b1;
        wait_pulse(20, lat);
        check("t6_held_latency", lat, D + 3);
        idle(1);
        btn_raw[0] = 1'b1;
        idle(10);

        // Reset during the pulse cycle drops the pulse
        btn_raw[0] = 1'b0;
        wait_pulse(20, lat);
        check("t6b_latency", lat, D + 3);
        #1;
        rst = 1'b0;
        #1;
        check_zero("t6b_pulse_reset");
        @(negedge clk);
        rst = 1'b1;
        wait_pulse(20, lat);
        check("t6b_held_latency", lat, D + 3);
        idle(1);
        btn_raw[0] = 1'b1;
        idle(12);

        // Random independent key activity
        for (int k = 0; k < NK; k++) hold[k] = 1;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NK; k++) begin
                hold[k]--;
                if (hold[k] == 0) begin
                    btn_raw[k] = ~btn_raw[k];
                    hold[k] = $urandom_range(1, 10);
                end
            end
            idle(1);
        end
        btn_raw = '1;
        idle(20);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
